riscv_base_div_writeback: RTL and testbench

- Downstream companion to the iterative divider. Tracks the one in-flight DIV/DIVU/REM/REMU: captures its destination register at issue and stalls dependent issue until the result is written.
- Merges the divider's result onto the single register-file write port shared with the single-cycle execute path. Execute always wins the port; a colliding divide result is held in a 1-entry buffer.
- Sits between the issue stage, the divider's writeback_valid_o/writeback_value_o, and the register file.

---
 rtl/riscv_base_div_writeback_pkg.sv | 24 ++
 rtl/riscv_base_div_writeback.sv | 134 +++++++++++++
 tb/tb_riscv_base_div_writeback.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_base_div_writeback_pkg.sv
// Shared types for the divide-writeback tracker: FSM encoding,
// register-index width and the default divide watchdog.
package riscv_base_div_writeback_pkg;

    localparam int REG_W           = 5;
    localparam int DIV_TIMEOUT_DEF = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // True when an issuing instruction touches the in-flight divide's rd.
    function automatic logic rd_hazard(
        input logic [REG_W-1:0] pend,
        input logic [REG_W-1:0] ra,
        input logic [REG_W-1:0] rb,
        input logic [REG_W-1:0] rd
    );
        return (pend != '0) && ((pend == ra) || (pend == rb) || (pend == rd));
    endfunction

endpackage

// File: rtl/riscv_base_div_writeback.sv
// Tracks the single in-flight divide and merges its result onto the
// register-file write port shared with the execute path.
module riscv_base_div_writeback
    import riscv_base_div_writeback_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    input  logic             issue_div_i,
    input  logic [REG_W-1:0] issue_rd_idx_i,
    input  logic [REG_W-1:0] issue_ra_idx_i,
    input  logic [REG_W-1:0] issue_rb_idx_i,
    input  logic             exec_valid_i,
    input  logic [REG_W-1:0] exec_rd_idx_i,
    input  logic [31:0]      exec_value_i,
    input  logic             div_valid_i,
    input  logic [31:0]      div_value_i,
    output logic             stall_o,
    output logic             div_pending_o,
    output logic             rf_we_o,
    output logic [REG_W-1:0] rf_rd_idx_o,
    output logic [31:0]      rf_value_o,
    output logic             timeout_o
);

    localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [REG_W-1:0] pend_rd_q, pend_rd_d;
    logic [31:0]      buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rf_we_q, rf_we_d;
    logic [REG_W-1:0] rf_idx_q, rf_idx_d;
    logic [31:0]      rf_val_q, rf_val_d;
    logic             timeout_q, timeout_d;

    logic             accept;
    logic             wsel;
    logic [REG_W-1:0] widx;
    logic [31:0]      wval;

    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            ST_WAIT: stall_o = issue_valid_i & (issue_div_i |
                rd_hazard(pend_rd_q, issue_ra_idx_i, issue_rb_idx_i, issue_rd_idx_i));
            ST_HOLD: stall_o = issue_valid_i;
            default: stall_o = 1'b0;
        endcase
    end

    assign accept = issue_valid_i & ~stall_o;

    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        wsel      = exec_valid_i;
        widx      = exec_rd_idx_i;
        wval      = exec_value_i;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && issue_div_i) begin
                    pend_rd_d = issue_rd_idx_i;
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (div_valid_i) begin
                    if (exec_valid_i) begin
                        buf_d   = div_value_i;
                        state_d = ST_HOLD;
                    end else begin
                        wsel    = 1'b1;
                        widx    = pend_rd_q;
                        wval    = div_value_i;
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Execute owns the port; drain the buffer on its first idle cycle.
                if (!exec_valid_i) begin
                    wsel    = 1'b1;
                    widx    = pend_rd_q;
                    wval    = buf_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rf_we_d  = wsel & (widx != '0);
        rf_idx_d = rf_we_d ? widx : rf_idx_q;
        rf_val_d = rf_we_d ? wval : rf_val_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pend_rd_q <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_idx_q  <= '0;
            rf_val_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_rd_q <= pend_rd_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            rf_we_q   <= rf_we_d;
            rf_idx_q  <= rf_idx_d;
            rf_val_q  <= rf_val_d;
            timeout_q <= timeout_d;
        end
    end

    assign div_pending_o = (state_q != ST_IDLE);
    assign rf_we_o       = rf_we_q;
    assign rf_rd_idx_o   = rf_idx_q;
    assign rf_value_o    = rf_val_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_riscv_base_div_writeback.sv
// Scoreboard bench: expected register writes are queued by the stimulus
// and popped by a negedge monitor whenever rf_we_o is asserted.
module tb_riscv_base_div_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_div;
    logic [4:0]  issue_rd, issue_ra, issue_rb;
    logic        exec_valid;
    logic [4:0]  exec_rd;
    logic [31:0] exec_value;
    logic        div_valid;
    logic [31:0] div_value;
    logic        stall, div_pending, rf_we, timeout;
    logic [4:0]  rf_idx;
    logic [31:0] rf_value;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    riscv_base_div_writeback #(.DIV_TIMEOUT(40)) dut (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_div_i(issue_div),
        .issue_rd_idx_i(issue_rd), .issue_ra_idx_i(issue_ra),
        .issue_rb_idx_i(issue_rb),
        .exec_valid_i(exec_valid), .exec_rd_idx_i(exec_rd),
        .exec_value_i(exec_value),
        .div_valid_i(div_valid), .div_value_i(div_value),
        .stall_o(stall), .div_pending_o(div_pending),
        .rf_we_o(rf_we), .rf_rd_idx_o(rf_idx), .rf_value_o(rf_value),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && rf_we) begin
            logic [36:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got x%0d=%h required none",
                         rf_idx, rf_value);
            end else begin
                e = exp_q.pop_front();
                if ({rf_idx, rf_value} !== e) begin
                    failures++;
                    $display("FAIL rf_write got x%0d=%h required x%0d=%h",
                             rf_idx, rf_value, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        issue_valid = 0; issue_div = 0;
        issue_rd = 0; issue_ra = 0; issue_rb = 0;
        exec_valid = 0; exec_rd = 0; exec_value = 0;
        div_valid = 0; div_value = 0;
    endtask

    task automatic issue(input logic d, input logic [4:0] rd,
                         input logic [4:0] ra, input logic [4:0] rb);
        issue_valid = 1; issue_div = d;
        issue_rd = rd; issue_ra = ra; issue_rb = rb;
    endtask

    initial begin
        int first, cnt;
        clear_in();
        rst = 1;
        tick(); tick();
        chk("reset_we", {31'd0, rf_we}, 0);
        chk("reset_idx", {27'd0, rf_idx}, 0);
        chk("reset_val", rf_value, 0);
        chk("reset_pending", {31'd0, div_pending}, 0);
        chk("reset_timeout", {31'd0, timeout}, 0);
        chk("reset_stall", {31'd0, stall}, 0);
        rst = 0;
        tick();

        // Basic divide, div_valid held 3 cycles
        issue(1, 5, 1, 2); #1;
        chk("idle_stall", {31'd0, stall}, 0);
        tick(); clear_in(); #1;
        chk("wait_pending", {31'd0, div_pending}, 1);
        issue(1, 6, 3, 4); #1;
        chk("wait_div_stall", {31'd0, stall}, 1);
        clear_in();
        tick(); tick(); tick();
        div_valid = 1; div_value = 32'h7;
        exp_q.push_back({5'd5, 32'h7});
        tick(); tick(); tick();
        chk("basic_done", {31'd0, div_pending}, 0);
        clear_in();
        tick();

        // Collision with execute
        issue(1, 10, 0, 0);
        tick(); clear_in();
        div_valid = 1; div_value = 32'h11;
        exec_valid = 1; exec_rd = 3; exec_value = 32'h22;
        exp_q.push_back({5'd3, 32'h22});
        tick();
        exec_rd = 4; exec_value = 32'h33;
        exp_q.push_back({5'd4, 32'h33});
        issue(0, 1, 1, 1); #1;
        chk("hold_stall_1", {31'd0, stall}, 1);
        tick();
        exec_valid = 0;
        exp_q.push_back({5'd10, 32'h11});
        #1;
        chk("hold_stall_2", {31'd0, stall}, 1);
        tick(); #1;
        chk("hold_done_stall", {31'd0, stall}, 0);
        chk("hold_done_pending", {31'd0, div_pending}, 0);
        clear_in();
        tick();

        // Hazard stall
        issue(1, 8, 0, 0);
        tick(); clear_in();
        issue(0, 9, 8, 1); #1;
        chk("haz_ra", {31'd0, stall}, 1);
        issue(0, 9, 1, 8); #1;
        chk("haz_rb", {31'd0, stall}, 1);
        issue(0, 8, 1, 2); #1;
        chk("haz_rd", {31'd0, stall}, 1);
        issue(0, 9, 1, 2);
        exec_valid = 1; exec_rd = 12; exec_value = 32'h44;
        exp_q.push_back({5'd12, 32'h44});
        #1;
        chk("haz_indep", {31'd0, stall}, 0);
        tick();
        exec_valid = 0;
        issue(0, 9, 8, 2);
        div_valid = 1; div_value = 32'h99;
        exp_q.push_back({5'd8, 32'h99});
        #1;
        chk("haz_last_wait", {31'd0, stall}, 1);
        tick();
        div_valid = 0; #1;
        chk("haz_released", {31'd0, stall}, 0);
        clear_in();
        tick();

        // Divide to x0, then a second divide
        issue(1, 0, 0, 0);
        tick(); clear_in();
        issue(0, 0, 0, 0); #1;
        chk("x0_no_hazard", {31'd0, stall}, 0);
        clear_in();
        div_valid = 1; div_value = 32'h5;
        tick(); clear_in(); #1;
        chk("x0_idle", {31'd0, div_pending}, 0);
        chk("x0_no_we", {31'd0, rf_we}, 0);
        issue(1, 7, 0, 0); #1;
        chk("second_div_stall", {31'd0, stall}, 0);
        tick(); clear_in(); #1;
        chk("second_div_pending", {31'd0, div_pending}, 1);
        div_valid = 1; div_value = 32'h77;
        exp_q.push_back({5'd7, 32'h77});
        tick(); clear_in();
        tick();

        // Timeout
        issue(1, 11, 0, 0);
        tick(); clear_in();
        first = 0; cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (timeout) begin
                if (first == 0) first = i;
                cnt++;
            end
        end
        chk("timeout_cycle", first, 40);
        chk("timeout_once", cnt, 1);
        chk("timeout_idle", {31'd0, div_pending}, 0);
        issue(1, 11, 0, 0); #1;
        chk("timeout_stall", {31'd0, stall}, 0);
        clear_in();
        tick();

        // Reset mid-operation
        issue(1, 13, 0, 0);
        tick(); clear_in();
        tick();
        rst = 1; #1;
        chk("rst_pending", {31'd0, div_pending}, 0);
        tick();
        rst = 0;
        tick();
        div_valid = 1; div_value = 32'hAB;
        tick(); tick(); tick();
        chk("rst_no_we", {31'd0, rf_we}, 0);
        chk("rst_not_pending", {31'd0, div_pending}, 0);
        clear_in();
        tick(); tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
